spi_reg_slave: RTL and testbench



---
 rtl/spi_reg_slave.sv | 231 +++++++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 target that bridges a command/data byte stream onto a
// byte-wide register port. The SPI pins are oversampled in the wb_clk_i domain, and
// wb_clk_i must run at least 8x SCLK.
//
// Frame format: a command byte, then data bytes, MSB first.
//   cmd[7]   : 1 = read, 0 = write
//   cmd[6:0] : start address, which post-increments per data byte and wraps 7F -> 00
//
// Ports:
//   wb_clk_i, wb_rst_n       system clock, asynchronous active-low reset
//   spi_clk_i/sel_i/mosi_i   SPI pins from the master (SEL active-low)
//   spi_miso_o, spi_miso_en  slave-out data and its output enable
//   reg_addr_o, reg_wdata_o  register address / write data
//   reg_we_o, reg_re_o       one-cycle write / read strobes
//   reg_rdata_i              read data, sampled one cycle after reg_re_o
//   frame_done_o             pulse when SEL deasserts
//   byte_err_o               pulse when a frame ends mid-byte
//
// Optional feature (define SPI_REG_SLAVE_STATUS_EN):
//   adds status_i[7:0]. The status byte is captured at SEL assertion and shifted out
//   on MISO while the command byte is received.
module spi_reg_slave #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              spi_clk_i,
    input  logic              spi_sel_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_en,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    input  logic [DATA_W-1:0] reg_rdata_i,
`ifdef SPI_REG_SLAVE_STATUS_EN
    input  logic [7:0]        status_i,
`endif
    output logic              frame_done_o,
    output logic              byte_err_o
);

    typedef enum logic [1:0] {StIdle, StCmd, StWdata, StRdata} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sel_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, sel_prev_q;
    logic                   sclk_s, sel_s, mosi_s;
    logic                   sclk_rise, sclk_fall, sel_rise, byte_done;

    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_in_q, shift_in_d, rx_byte;
    logic [DATA_W-1:0] shift_out_q, shift_out_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic              rbuf_vld_q, rbuf_vld_d;
    logic              re_dly_q;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d, re_q, re_d, done_q, done_d, err_q, err_d;

    logic [DATA_W-1:0] status_load;
    logic              cmd_miso_en;

`ifdef SPI_REG_SLAVE_STATUS_EN
    assign status_load = status_i;
    assign cmd_miso_en = 1'b1;
`else
    assign status_load = '0;
    assign cmd_miso_en = 1'b0;
`endif

    // Synchronisers, preset to the idle bus state (SCLK=0, SEL=1, MOSI=0).
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sclk_sync_q <= '0;
            sel_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            sel_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
            sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], spi_sel_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sclk_prev_q <= sclk_s;
            sel_prev_q  <= sel_s;
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign sel_s  = sel_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // SCLK edges only count while selected.
    assign sclk_rise = sclk_s & ~sclk_prev_q & ~sel_s;
    assign sclk_fall = ~sclk_s & sclk_prev_q & ~sel_s;
    assign sel_rise  = sel_s & ~sel_prev_q;

    assign rx_byte   = {shift_in_q[6:0], mosi_s};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
    assign addr_inc  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        rbuf_d      = rbuf_q;
        rbuf_vld_d  = rbuf_vld_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        // Write address post-increments once the strobe carrying it has gone out.
        if (we_q) begin
            addr_d = addr_inc;
        end

        case (state_q)
            StIdle: begin
                bit_cnt_d   = 3'd0;
                shift_in_d  = 8'h00;
                rbuf_vld_d  = 1'b0;
                // Tracks status while idle, so it holds the value at SEL assertion.
                shift_out_d = status_load;
                if (!sel_s) begin
                    state_d = StCmd;
                end
            end
            default: begin
                if (sel_rise) begin
                    // A partial byte is dropped without a strobe.
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    err_d     = (bit_cnt_q != 3'd0);
                    bit_cnt_d = 3'd0;
                end else begin
                    if (sclk_rise) begin
                        shift_in_d = rx_byte;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                    end
                    if (sclk_fall) begin
                        // A pending read byte replaces the shifter, so its bit 7 is
                        // presented at this fall.
                        if (rbuf_vld_q) begin
                            shift_out_d = rbuf_q;
                            rbuf_vld_d  = 1'b0;
                        end else begin
                            shift_out_d = {shift_out_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    if (re_dly_q) begin
                        rbuf_d     = reg_rdata_i;
                        rbuf_vld_d = 1'b1;
                    end
                    if (byte_done) begin
                        case (state_q)
                            StCmd: begin
                                addr_d = rx_byte[ADDR_W-1:0];
                                if (rx_byte[7]) begin
                                    state_d = StRdata;
                                    re_d    = 1'b1;
                                end else begin
                                    state_d = StWdata;
                                end
                            end
                            StWdata: begin
                                we_d    = 1'b1;
                                wdata_d = rx_byte;
                            end
                            StRdata: begin
                                // Prefetch the next byte before the next SCLK fall.
                                addr_d = addr_inc;
                                re_d   = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            shift_in_q  <= 8'h00;
            shift_out_q <= '0;
            rbuf_q      <= '0;
            rbuf_vld_q  <= 1'b0;
            re_dly_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            rbuf_q      <= rbuf_d;
            rbuf_vld_q  <= rbuf_vld_d;
            re_dly_q    <= re_q;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign spi_miso_en  = ~sel_s & ((state_q == StRdata) | (cmd_miso_en & (state_q == StCmd)));
    assign spi_miso_o   = spi_miso_en & shift_out_q[DATA_W-1];
    assign reg_addr_o   = addr_q;
    assign reg_wdata_o  = wdata_q;
    assign reg_we_o     = we_q;
    assign reg_re_o     = re_q;
    assign frame_done_o = done_q;
    assign byte_err_o   = err_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
module tb_spi_reg_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       spi_clk = 1'b0;
    logic       sel = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_en;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       we, re;
    logic [7:0] rdata = 8'h00;
    logic       done, err;
    logic [7:0] status = 8'hC3;

`ifdef SPI_REG_SLAVE_STATUS_EN
    localparam bit StatusEn = 1'b1;
`else
    localparam bit StatusEn = 1'b0;
`endif

    spi_reg_slave dut (
        .wb_clk_i    (clk),
        .wb_rst_n    (rst_n),
        .spi_clk_i   (spi_clk),
        .spi_sel_i   (sel),
        .spi_mosi_i  (mosi),
        .spi_miso_o  (miso),
        .spi_miso_en (miso_en),
        .reg_addr_o  (addr),
        .reg_wdata_o (wdata),
        .reg_we_o    (we),
        .reg_re_o    (re),
        .reg_rdata_i (rdata),
`ifdef SPI_REG_SLAVE_STATUS_EN
        .status_i    (status),
`endif
        .frame_done_o(done),
        .byte_err_o  (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Expected strobes {is_read, addr, wdata}, and what the DUT actually issued.
    logic [16:0] exp_q[$];
    logic [16:0] log_q[$];
    logic [7:0]  rx_q[$];
    logic [16:0] mon_got;
    int          done_cnt = 0;
    int          err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register file model: rdata = addr ^ 8'hFF, presented exactly one cycle after reg_re_o.
    bit         rd_pend = 1'b0;
    logic [7:0] rd_val = 8'h00;
    always @(negedge clk) begin
        rdata   = rd_pend ? rd_val : 8'($urandom);
        rd_pend = re;
        rd_val  = ~{1'b0, addr};
    end

    // Compare process: every strobe is checked against the model's queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {11'd0, miso, miso_en, addr, wdata, we, re, done, err}, 32'd0);
        end else begin
            if (we || re) begin
                mon_got = {re, addr, (we ? wdata : 8'h00)};
                log_q.push_back(mon_got);
                if (we && re) begin
                    check("we_re_exclusive", {31'd0, we & re}, 32'd0);
                end
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_strobe: got %0h, expected none (t=%0t)",
                             mon_got, $time);
                end else begin
                    check("strobe", {15'd0, mon_got}, {15'd0, exp_q.pop_front()});
                end
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
    end

    task automatic hold(input int lo, input int hi);
        repeat ($urandom_range(hi, lo)) @(negedge clk);
    endtask

    // Builds the expected strobes and MISO bits, then drives one mode-0 frame.
    // nbits may stop mid-byte. rst_at >= 0 asserts reset just before that bit's rise.
    task automatic run_frame(input logic [7:0] tx[$], input int nbits, input int rst_at);
        int         nfull, b, j;
        bit         rd;
        logic [6:0] base, a;
        logic [7:0] v, cur;
        bit         exp_bit[$], exp_en[$];

        nfull = nbits / 8;
        rd    = 1'b0;
        base  = 7'd0;
        cur   = 8'h00;
        if (nfull >= 1) begin
            v    = tx[0];
            base = v[6:0];
            rd   = v[7];
            a    = base;
            if (rd) begin
                // Command read plus one prefetch per completed data byte.
                for (int i = 0; i < nfull; i++) begin
                    exp_q.push_back({1'b1, a, 8'h00});
                    a = a + 7'd1;
                end
            end else begin
                for (int i = 1; i < nfull; i++) begin
                    exp_q.push_back({1'b0, a, tx[i]});
                    a = a + 7'd1;
                end
            end
        end
        for (int k = 0; k < nbits; k++) begin
            b = k / 8;
            j = 7 - (k % 8);
            if (b == 0) begin
                v = StatusEn ? status : 8'h00;
                exp_en.push_back(StatusEn);
                exp_bit.push_back(v[j]);
            end else if (rd) begin
                a = base + 7'(b - 1);
                v = ~{1'b0, a};
                exp_en.push_back(1'b1);
                exp_bit.push_back(v[j]);
            end else begin
                exp_en.push_back(1'b0);
                exp_bit.push_back(1'b0);
            end
        end

        rx_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        @(negedge clk);
        sel = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            v    = tx[k / 8];
            mosi = v[7 - (k % 8)];
            hold(4, 7);
            if (k == rst_at) begin
                @(posedge clk);
                #1 rst_n = 1'b0;
                sel     = 1'b1;
                spi_clk = 1'b0;
                mosi    = 1'b0;
                exp_q.delete();
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (4) @(negedge clk);
                return;
            end
            check("miso_en", {31'd0, miso_en}, {31'd0, exp_en[k]});
            check("miso", {31'd0, miso}, {31'd0, exp_bit[k]});
            cur = {cur[6:0], miso};
            if ((k % 8) == 7) rx_q.push_back(cur);
            spi_clk = 1'b1;
            hold(4, 7);
            spi_clk = 1'b0;
        end
        hold(4, 7);
        sel  = 1'b1;
        mosi = 1'b0;
        repeat (12) @(negedge clk);
        check("frame_done_count", done_cnt, 1);
        check("byte_err_count", err_cnt, ((nbits % 8) != 0) ? 1 : 0);
        check("strobes_outstanding", exp_q.size(), 0);
        check("miso_en_after_frame", {31'd0, miso_en}, 32'd0);
        exp_q.delete();
    endtask

    // SCLK toggling while deselected must produce nothing.
    task automatic sclk_glitch();
        done_cnt = 0;
        repeat (3) begin
            spi_clk = 1'b1;
            repeat (4) @(negedge clk);
            spi_clk = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        check("glitch_no_frame", done_cnt, 0);
    endtask

    logic [7:0] tx[$];
    int         nb, part;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single write.
        log_q.delete();
        tx = '{8'h05, 8'hA5};
        run_frame(tx, 16, -1);
        check("wr1_count", log_q.size(), 1);
        check("wr1_entry", {15'd0, log_q[0]}, {15'd0, 1'b0, 7'h05, 8'hA5});

        // Burst write across the address wrap.
        log_q.delete();
        tx = '{8'h7E, 8'h11, 8'h22, 8'h33};
        run_frame(tx, 32, -1);
        check("wrap_count", log_q.size(), 3);
        check("wrap_0", {15'd0, log_q[0]}, {15'd0, 1'b0, 7'h7E, 8'h11});
        check("wrap_1", {15'd0, log_q[1]}, {15'd0, 1'b0, 7'h7F, 8'h22});
        check("wrap_2", {15'd0, log_q[2]}, {15'd0, 1'b0, 7'h00, 8'h33});

        // Burst read with prefetch.
        log_q.delete();
        tx = '{8'h90, 8'h00, 8'h00, 8'h00};
        run_frame(tx, 32, -1);
        check("rd_count", log_q.size(), 4);
        check("rd_addr_last", {15'd0, log_q[3]}, {15'd0, 1'b1, 7'h13, 8'h00});
        check("rd_byte1", {24'd0, rx_q[1]}, 32'hEF);
        check("rd_byte2", {24'd0, rx_q[2]}, 32'hEE);
        check("rd_byte3", {24'd0, rx_q[3]}, 32'hED);

        // Abort after 5 bits of a write data byte, then a normal frame.
        log_q.delete();
        tx = '{8'h20, 8'hFF};
        run_frame(tx, 13, -1);
        check("abort_no_write", log_q.size(), 0);
        tx = '{8'h21, 8'h5A};
        run_frame(tx, 16, -1);
        check("after_abort", {15'd0, log_q[0]}, {15'd0, 1'b0, 7'h21, 8'h5A});

        // SEL pulse with no SCLK activity.
        log_q.delete();
        tx = '{8'h00};
        run_frame(tx, 0, -1);
        check("empty_frame_no_strobe", log_q.size(), 0);

        // Reset in the middle of a read, then a clean write.
        tx = '{8'h90, 8'h00};
        run_frame(tx, 16, 12);
        log_q.delete();
        tx = '{8'h01, 8'h3C};
        run_frame(tx, 16, -1);
        check("post_reset_write", {15'd0, log_q[0]}, {15'd0, 1'b0, 7'h01, 8'h3C});

        sclk_glitch();

        // Random frames, some ending mid-byte.
        for (int f = 0; f < 40; f++) begin
            tx.delete();
            nb   = $urandom_range(4, 0);
            part = ($urandom_range(3, 0) == 0) ? $urandom_range(7, 1) : 0;
            for (int i = 0; i < nb + ((part != 0) ? 1 : 0); i++) tx.push_back(8'($urandom));
            if (tx.size() == 0) tx.push_back(8'h00);
            if ($urandom_range(4, 0) == 0) sclk_glitch();
            run_frame(tx, nb * 8 + part, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
